// File: rtl/limn2600_pkg.sv
// Shared types and widths for the Limn2600 SRAM controller.
//   sram_state_t : controller FSM encoding
//   sram_cmd_t   : command latched from the scheduler in IDLE
package limn2600_pkg;

    localparam int unsigned LIMN_WORD_W = 32;
    localparam int unsigned LIMN_BE_W   = 4;
    localparam int unsigned LIMN_WAIT_W = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        ACCESS  = 3'd2,
        HOLD    = 3'd3,
        DONE    = 3'd4,
        RECOVER = 3'd5
    } sram_state_t;

    typedef struct packed {
        logic                   we;
        logic [LIMN_WORD_W-1:0] addr;
        logic [LIMN_WORD_W-1:0] wdata;
        logic [LIMN_BE_W-1:0]   be;
    } sram_cmd_t;

endpackage

// File: rtl/limn2600_sram_wait_ctr.sv
// Wait-state counter: loads a start value, decrements to zero and stops there.
//   clk, rst      : clock, synchronous active-high reset
//   load/load_val : load the counter (has priority over dec)
//   dec           : decrement by one, saturating at zero
//   zero_c        : combinational flag, counter is zero
module limn2600_sram_wait_ctr
    import limn2600_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [LIMN_WAIT_W-1:0] load_val,
    input  logic                   dec,
    output logic                   zero_c
);

    logic [LIMN_WAIT_W-1:0] count;

    // Load / saturating decrement
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - LIMN_WAIT_W'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/limn2600_sram_ctrl.sv
// RAM-side controller for the Limn2600 memory scheduler, driving an external
// asynchronous 32-bit SRAM with programmable wait states.
//   clk, rst                      : clock, synchronous active-high reset
//   cmd_ce/we/addr/wdata[/be]     : command level from the scheduler, held until cmd_rdy
//   cmd_rdata/cmd_rdy/cmd_err     : one-cycle completion pulse, read data, range error
//   sram_addr/dq_o/dq_oe/dq_i     : SRAM word address and data (pad tristate is external)
//   sram_ce_n/oe_n/we_n/be_n      : SRAM strobes, active low, all registered
// Build option: LIMN_SRAM_BYTE_LANES_EN adds cmd_be and per-lane write masking.
module limn2600_sram_ctrl
    import limn2600_pkg::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_ce,
    input  logic                   cmd_we,
    input  logic [LIMN_WORD_W-1:0] cmd_addr,
    input  logic [LIMN_WORD_W-1:0] cmd_wdata,
`ifdef LIMN_SRAM_BYTE_LANES_EN
    input  logic [LIMN_BE_W-1:0]   cmd_be,
`endif
    output logic [LIMN_WORD_W-1:0] cmd_rdata,
    output logic                   cmd_rdy,
    output logic                   cmd_err,
    output logic [ADDR_W-1:0]      sram_addr,
    output logic [LIMN_WORD_W-1:0] sram_dq_o,
    input  logic [LIMN_WORD_W-1:0] sram_dq_i,
    output logic                   sram_dq_oe,
    output logic                   sram_ce_n,
    output logic                   sram_oe_n,
    output logic                   sram_we_n,
    output logic [LIMN_BE_W-1:0]   sram_be_n
);

    sram_state_t state, state_d;
    sram_cmd_t   lat;
    sram_cmd_t   in_cmd_c;
    sram_cmd_t   cur_c;
    logic        in_range_c;
    logic        wait_zero_c;

    logic [LIMN_WORD_W-1:0] cmd_rdata_d;
    logic                   cmd_rdy_d;
    logic                   cmd_err_d;
    logic [ADDR_W-1:0]      sram_addr_d;
    logic [LIMN_WORD_W-1:0] sram_dq_o_d;
    logic                   sram_dq_oe_d;
    logic                   sram_ce_n_d;
    logic                   sram_oe_n_d;
    logic                   sram_we_n_d;
    logic [LIMN_BE_W-1:0]   sram_be_n_d;

    // Incoming command as a struct; without lane enables every lane is written
    always_comb begin
        in_cmd_c.we    = cmd_we;
        in_cmd_c.addr  = cmd_addr;
        in_cmd_c.wdata = cmd_wdata;
`ifdef LIMN_SRAM_BYTE_LANES_EN
        in_cmd_c.be    = cmd_be;
`else
        in_cmd_c.be    = '1;
`endif
    end

    // Outputs for SETUP are computed in IDLE, before the latch is loaded
    assign cur_c      = (state == IDLE) ? in_cmd_c : lat;
    assign in_range_c = ((cmd_addr >> (ADDR_W + 2)) == '0);

    // Byte-offset bits, out-of-range upper bits and (without lanes) be are don't-cares
    logic unused_bits;
    assign unused_bits = ^{lat.addr, lat.be, cmd_addr[1:0]};

    // Command latch; inputs are ignored outside IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            lat <= '0;
        end else if ((state == IDLE) && cmd_ce) begin
            lat <= in_cmd_c;
        end
    end

    limn2600_sram_wait_ctr u_wait_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (state == SETUP),
        .load_val (LIMN_WAIT_W'(WAIT_STATES)),
        .dec      (state == ACCESS),
        .zero_c   (wait_zero_c)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (cmd_ce) begin
                    state_d = in_range_c ? SETUP : DONE;
                end
            end
            SETUP:   state_d = ACCESS;
            ACCESS: begin
                if (wait_zero_c) begin
                    state_d = lat.we ? HOLD : DONE;
                end
            end
            HOLD:    state_d = DONE;
            DONE:    state_d = RECOVER;
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode: values for the registers, keyed on the state being entered
    always_comb begin
        cmd_rdy_d    = 1'b0;
        cmd_err_d    = 1'b0;
        cmd_rdata_d  = '0;
        sram_addr_d  = sram_addr;
        sram_dq_o_d  = sram_dq_o;
        sram_dq_oe_d = 1'b0;
        sram_ce_n_d  = 1'b1;
        sram_oe_n_d  = 1'b1;
        sram_we_n_d  = 1'b1;
        sram_be_n_d  = '1;

        case (state_d)
            SETUP, ACCESS, HOLD: begin
                sram_ce_n_d = 1'b0;
                sram_addr_d = cur_c.addr[ADDR_W+1:2];
                sram_be_n_d = cur_c.we ? ~cur_c.be : '0;
                if (cur_c.we) begin
                    sram_dq_oe_d = 1'b1;
                    sram_dq_o_d  = cur_c.wdata;
                end
                if (state_d == ACCESS) begin
                    if (cur_c.we) begin
                        sram_we_n_d = 1'b0;
                    end else begin
                        sram_oe_n_d = 1'b0;
                    end
                end
            end
            DONE: begin
                cmd_rdy_d = 1'b1;
                // Entering DONE straight from IDLE only happens on a range error
                cmd_err_d = (state == IDLE);
                if ((state == ACCESS) && !lat.we) begin
                    cmd_rdata_d = sram_dq_i;
                end
            end
            default: ;
        endcase
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_rdy    <= 1'b0;
            cmd_err    <= 1'b0;
            cmd_rdata  <= '0;
            sram_addr  <= '0;
            sram_dq_o  <= '0;
            sram_dq_oe <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_be_n  <= '1;
        end else begin
            cmd_rdy    <= cmd_rdy_d;
            cmd_err    <= cmd_err_d;
            cmd_rdata  <= cmd_rdata_d;
            sram_addr  <= sram_addr_d;
            sram_dq_o  <= sram_dq_o_d;
            sram_dq_oe <= sram_dq_oe_d;
            sram_ce_n  <= sram_ce_n_d;
            sram_oe_n  <= sram_oe_n_d;
            sram_we_n  <= sram_we_n_d;
            sram_be_n  <= sram_be_n_d;
        end
    end

endmodule

// File: tb/tb_limn2600_sram_ctrl.sv
// Self-checking bench for limn2600_sram_ctrl (WAIT_STATES=1, ADDR_W=16) with an
// SRAM behavioural model and a bus timing monitor.
module tb_limn2600_sram_ctrl;

    localparam int unsigned ADDR_W = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_ce = 1'b0;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_be = 4'hF;
    logic [31:0] cmd_rdata;
    logic        cmd_rdy;
    logic        cmd_err;
    logic [ADDR_W-1:0] sram_addr;
    logic [31:0] sram_dq_o;
    logic [31:0] sram_dq_i;
    logic        sram_dq_oe;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic [3:0]  sram_be_n;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    limn2600_sram_ctrl #(.ADDR_W(ADDR_W), .WAIT_STATES(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_ce     (cmd_ce),
        .cmd_we     (cmd_we),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
`ifdef LIMN_SRAM_BYTE_LANES_EN
        .cmd_be     (cmd_be),
`endif
        .cmd_rdata  (cmd_rdata),
        .cmd_rdy    (cmd_rdy),
        .cmd_err    (cmd_err),
        .sram_addr  (sram_addr),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_i  (sram_dq_i),
        .sram_dq_oe (sram_dq_oe),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n),
        .sram_be_n  (sram_be_n)
    );

    // SRAM model: async read, lane-masked write while ce_n/we_n low and data driven
    logic [31:0] mem [0:65535];
    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 32'h0;

    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
            for (int l = 0; l < 4; l++) begin
                if (!sram_be_n[l]) mem[sram_addr][8*l +: 8] <= sram_dq_o[8*l +: 8];
            end
        end
    end

    // Timing monitor: bus contention, turnaround, strobe sanity, double completion
    int viol_contention = 0;
    int viol_turnaround = 0;
    int viol_strobes    = 0;
    int viol_double_rdy = 0;
    logic prev_dq_oe = 1'b0;
    logic prev_rdy   = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (sram_dq_oe && !sram_oe_n) viol_contention++;
            if (prev_dq_oe && !sram_oe_n) viol_turnaround++;
            if ((!sram_oe_n || !sram_we_n) && sram_ce_n) viol_strobes++;
            if (!sram_oe_n && !sram_we_n) viol_strobes++;
            if (prev_rdy && cmd_rdy) viol_double_rdy++;
        end
        prev_dq_oe = sram_dq_oe;
        prev_rdy   = cmd_rdy;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Results of the last access
    logic [31:0] r_rdata;
    logic        r_err;
    int          r_lat;
    logic [31:0] m_ce, m_oe, m_we, m_dqoe;
    logic [31:0] r_addr1;
    logic [3:0]  r_be2;

    // One access with cmd_ce held until cmd_rdy; cycle 0 is the first cmd_ce cycle
    task automatic do_acc(input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be);
        m_ce = '0; m_oe = '0; m_we = '0; m_dqoe = '0;
        r_addr1 = '0; r_be2 = '0; r_lat = -1; r_rdata = '0; r_err = 1'b0;
        @(posedge clk); #1;
        cmd_ce = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wdata; cmd_be = be;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c < 32) begin
                m_ce[c]   = !sram_ce_n;
                m_oe[c]   = !sram_oe_n;
                m_we[c]   = !sram_we_n;
                m_dqoe[c] = sram_dq_oe;
            end
            if (c == 1) r_addr1 = 32'(sram_addr);
            if (c == 2) r_be2 = sram_be_n;
            if (cmd_rdy) begin
                r_lat = c; r_rdata = cmd_rdata; r_err = cmd_err;
                break;
            end
        end
        if (r_lat < 0) begin
            errors++; checks++;
            $display("FAIL access_timeout: addr 0x%08h no cmd_rdy within 40 cycles", addr);
        end
        @(posedge clk); #1;
        cmd_ce = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs [8];
    int   pos [3];
    int   pulses;
    int   extra;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
        mem[4]  = 32'hDEADBEEF;
        mem[16] = 32'h11223344;

        vecs[0] = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEADBEEF, 1'b0, 4};
        vecs[1] = '{1'b1, 32'h0000_0020, 32'h12345678,  32'h0,        1'b0, 5};
        vecs[2] = '{1'b0, 32'h0000_0020, 32'h0,         32'h12345678, 1'b0, 4};
        vecs[3] = '{1'b0, 32'h0004_0000, 32'h0,         32'h0,        1'b1, 1};
        vecs[4] = '{1'b1, 32'hFFFF_FFFC, 32'h55555555,  32'h0,        1'b1, 1};
        vecs[5] = '{1'b1, 32'h0003_FFFC, 32'hA5A55A5A,  32'h0,        1'b0, 5};
        vecs[6] = '{1'b0, 32'h0003_FFFF, 32'h0,         32'hA5A55A5A, 1'b0, 4};
        vecs[7] = '{1'b0, 32'h0000_0022, 32'h0,         32'h12345678, 1'b0, 4};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", {22'h0, cmd_rdy, cmd_err, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n, sram_dq_oe},
            32'({1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 1'b0}));
        chk("reset_rdata", cmd_rdata, 32'h0);
        chk("reset_addr",  32'(sram_addr), 32'h0);
        chk("reset_dq_o",  sram_dq_o, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Table vectors
        for (int i = 0; i < 8; i++) begin
            do_acc(vecs[i].we, vecs[i].addr, vecs[i].wdata, 4'hF);
            chk($sformatf("vec%0d_rdata", i), r_rdata, vecs[i].rdata);
            chk($sformatf("vec%0d_err", i), 32'(r_err), 32'(vecs[i].err));
            chk($sformatf("vec%0d_latency", i), 32'(r_lat), 32'(vecs[i].lat));
        end

        // Read strobe timing
        do_acc(1'b0, 32'h0000_0010, 32'h0, 4'hF);
        chk("rd_sram_addr", r_addr1, 32'h0000_0004);
        chk("rd_oe_cycles", m_oe, 32'h0000_000C);
        chk("rd_we_cycles", m_we, 32'h0);
        chk("rd_dqoe_cycles", m_dqoe, 32'h0);
        chk("rd_be_n", 32'(r_be2), 32'h0);
        chk("rd_data", r_rdata, 32'hDEADBEEF);

        // Write strobe timing
        do_acc(1'b1, 32'h0000_0020, 32'h12345678, 4'hF);
        chk("wr_we_cycles", m_we, 32'h0000_000C);
        chk("wr_dqoe_cycles", m_dqoe, 32'h0000_001E);
        chk("wr_oe_cycles", m_oe, 32'h0);
        chk("wr_ce_cycles", m_ce, 32'h0000_001E);
        chk("wr_latency", 32'(r_lat), 32'd5);
        chk("wr_model_word8", mem[8], 32'h12345678);

        // Out of range: no SRAM activity
        do_acc(1'b0, 32'h0004_0000, 32'h0, 4'hF);
        chk("err_ce_never_low", m_ce, 32'h0);
        chk("err_flag", 32'(r_err), 32'h1);
        chk("err_rdata", r_rdata, 32'h0);

        // Back-to-back reads with cmd_ce held high
        pos = '{-1, -1, -1};
        pulses = 0;
        @(posedge clk); #1;
        cmd_ce = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h0000_0010;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (cmd_rdy) begin
                pos[pulses] = c;
                chk($sformatf("b2b_rdata%0d", pulses), cmd_rdata, 32'hDEADBEEF);
                pulses++;
                if (pulses == 3) break;
            end
        end
        @(posedge clk); #1;
        cmd_ce = 1'b0;
        extra = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (cmd_rdy) extra++;
        end
        chk("b2b_pulse0", 32'(pos[0]), 32'd4);
        chk("b2b_pulse1", 32'(pos[1]), 32'd10);
        chk("b2b_pulse2", 32'(pos[2]), 32'd16);
        chk("b2b_no_extra", 32'(extra), 32'd0);

        // Reset in cycle 2 of a write
        @(posedge clk); #1;
        cmd_ce = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h0000_0030; cmd_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_we_active", 32'(sram_we_n), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; cmd_ce = 1'b0;
        @(negedge clk);
        chk("rst_mid_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, cmd_rdy, sram_be_n}),
            32'({1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'hF}));
        extra = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (cmd_rdy) extra++;
        end
        chk("rst_mid_no_rdy", 32'(extra), 32'd0);
        do_acc(1'b0, 32'h0000_0010, 32'h0, 4'hF);
        chk("post_rst_rdata", r_rdata, 32'hDEADBEEF);
        chk("post_rst_latency", 32'(r_lat), 32'd4);

`ifdef LIMN_SRAM_BYTE_LANES_EN
        // Single-lane write
        do_acc(1'b1, 32'h0000_0040, 32'h00AA0000, 4'b0100);
        chk("be_sram_be_n", 32'(r_be2), 32'h0000_000B);
        do_acc(1'b0, 32'h0000_0040, 32'h0, 4'hF);
        chk("be_readback", r_rdata, 32'h11AA3344);
        do_acc(1'b1, 32'h0000_0040, 32'hFFFFFFFF, 4'b0000);
        chk("be_masked_latency", 32'(r_lat), 32'd5);
        chk("be_masked_word", mem[16], 32'h11AA3344);
`endif

        // Bus timing monitor results
        chk("mon_contention", 32'(viol_contention), 32'd0);
        chk("mon_turnaround", 32'(viol_turnaround), 32'd0);
        chk("mon_strobes", 32'(viol_strobes), 32'd0);
        chk("mon_double_rdy", 32'(viol_double_rdy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
